// File: rtl/m_ext_pkg.sv
// rtl/m_ext_pkg.sv - shared RV32M opcode and iterative-unit FSM encodings
package m_ext_pkg;

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  // State encoding shared by iter_mul32 and iter_div32
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } m_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/iter_div32.sv
// rtl/iter_div32.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module iter_div32
  import m_ext_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  op_sel,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  m_state_e    state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] quo;
  logic [31:0] dsr;
  logic [32:0] rem;
  logic [31:0] rs1_q;
  logic        a_neg, b_neg, div0, want_rem;

  logic        is_signed;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] q_out, r_out;
  logic        sig_unused;

  // Only the low opcode bits matter; rem[32] is always clear after a restoring step
  assign sig_unused = ^{op_sel[4:2], rem[32]};

  assign is_signed = ~op_sel[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (cnt == 5'd31) state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rem_sh = {rem[31:0], quo[31]};
    diff   = rem_sh - {1'b0, dsr};
    q_out  = (a_neg ^ b_neg) ? neg32(quo) : quo;
    r_out  = a_neg ? neg32(rem[31:0]) : rem[31:0];
    // RISC-V divide-by-zero results take precedence over sign fixup
    if (div0) begin
      q_out = 32'hFFFF_FFFF;
      r_out = rs1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      quo      <= '0;
      dsr      <= '0;
      rem      <= '0;
      rs1_q    <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      div0     <= 1'b0;
      want_rem <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            want_rem <= op_sel[1];
            a_neg    <= is_signed & rs1[31];
            b_neg    <= is_signed & rs2[31];
            div0     <= (rs2 == 32'd0);
            rs1_q    <= rs1;
            quo      <= (is_signed & rs1[31]) ? neg32(rs1) : rs1;
            dsr      <= (is_signed & rs2[31]) ? neg32(rs2) : rs2;
            rem      <= '0;
            cnt      <= '0;
          end
        end
        S_RUN: begin
          cnt <= cnt + 5'd1;
          if (!diff[32]) begin
            rem <= diff;
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= {quo[30:0], 1'b0};
          end
        end
        S_FIX: result <= want_rem ? r_out : q_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div32.sv
// tb/tb_iter_div32.sv - directed self-checking bench for iter_div32
module tb_iter_div32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op_sel = 5'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] DIV  = 5'b10100;
  localparam logic [4:0] DIVU = 5'b10101;
  localparam logic [4:0] REM  = 5'b10110;
  localparam logic [4:0] REMU = 5'b10111;

  iter_div32 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sel (op_sel),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Issue one op, wait for done, return result and cycles-to-done; leaves bench in the IDLE cycle after DONE
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    op_sel = op; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; op_sel = 5'b00000;
    lat = -1;
    res = 'x;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        lat = c;
        res = result;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b result=%h required 0/0/0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_latency();
    int busy_bad = 0;
    int done_at = -1;
    int overlap = 0;
    @(negedge clk);
    op_sel = DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs1 = 32'd0; rs2 = 32'd0;
    for (int c = 1; c <= 36; c++) begin
      if ((c <= 33) !== busy) busy_bad++;
      if (done && done_at < 0) done_at = c;
      if (done && busy) overlap++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL busy_window wrong_cycles=%0d required 0", busy_bad);
    end
    checks++;
    if (done_at != 34) begin
      errors++;
      $display("FAIL done_latency got=%0d required 34", done_at);
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL done_busy_overlap got=%0d required 0", overlap);
    end
    checks++;
    if (result !== 32'd14) begin
      errors++;
      $display("FAIL divu_100_7 got=%h required %h", result, 32'd14);
    end
  endtask

  task automatic test_ops();
    logic [4:0]  ops [10] = '{REMU, DIV, REM, REM, DIV, DIVU, REM, REMU, DIV, REM};
    logic [31:0] as  [10] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'hFFFF_FFFF,
                              32'hFFFF_FFFB, 32'd9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [10] = '{32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [10] = '{32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFB, 32'd9, 32'h8000_0000, 32'd0};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat);
      checks++;
      if (res !== exp[i] || lat != 34) begin
        errors++;
        $display("FAIL op_vec%0d op=%b a=%h b=%h got=%h lat=%0d required %h lat=34",
                 i, ops[i], as[i], bs[i], res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int done_at = -1;
    int extra_busy = 0;
    @(negedge clk);
    op_sel = DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (c == 5) begin
        op_sel = DIV; rs1 = 32'd1000; rs2 = 32'd10; start = 1'b1;
      end else if (c == 6) begin
        start = 1'b0;
      end
      if (c == 34 && done) begin
        done_at = c;
        start = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (done_at != 34) begin
      errors++;
      $display("FAIL ignore_done_latency got=%0d required 34", done_at);
    end
    for (int c = 0; c < 5; c++) begin
      if (busy || done) extra_busy++;
      @(posedge clk); #1;
    end
    checks++;
    if (extra_busy != 0) begin
      errors++;
      $display("FAIL start_in_done_accepted active_cycles=%0d required 0", extra_busy);
    end
    checks++;
    if (result !== 32'd14) begin
      errors++;
      $display("FAIL ignore_result got=%h required %h", result, 32'd14);
    end
  endtask

  task automatic test_mid_reset();
    int spurious = 0;
    logic [31:0] res;
    int lat;
    @(negedge clk);
    op_sel = DIVU; rs1 = 32'd500; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b result=%h required 0/0/0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL after_reset_activity got=%0d required 0", spurious);
    end
    run_op(DIVU, 32'hFFFF_FFFF, 32'd1, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFF || lat != 34) begin
      errors++;
      $display("FAIL post_reset_divu got=%h lat=%0d required ffffffff lat=34", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ops();
    test_start_ignored();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
